pe_dot_seq: RTL and testbench

//  Sequences one FP32 pe (multiply then accumulate, variable latency) through an N-term dot product.
//  - Accepts a job command (length, initial psum) and a stream of (a,b) operand pairs.
//  - Issues one pe operation per pair and chains the psum.
//  - Returns the final FP32 sum, or an error, through a result handshake.
//  - Sits between the attention-score datapath feeders and a single pe instance.

---
 rtl/pe_dot_seq.sv | 127 ++++++++++++
 tb/tb_pe_dot_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dot_seq.sv
`default_nettype none
// ============================================================================
// Module      : pe_dot_seq
// Description : Drives one multiply-accumulate pe through an N-term FP32 dot
//               product and returns the chained psum (or a timeout error).
// Revision    : 1.0 - initial release
// ============================================================================
module pe_dot_seq #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      cmd_init,
    input  logic             elem_valid,
    output logic             elem_ready,
    input  logic [31:0]      elem_a,
    input  logic [31:0]      elem_b,
    output logic             pe_in_valid,
    output logic [31:0]      pe_a_bits,
    output logic [31:0]      pe_b_bits,
    output logic [31:0]      pe_psum_in,
    input  logic             pe_out_valid,
    input  logic [31:0]      pe_psum_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [LEN_W-1:0] res_count,
    output logic             res_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    localparam int                c_TO_W    = $clog2(TIMEOUT);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    state_t             r_state;
    logic [31:0]        r_acc;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_err;
    logic [c_TO_W-1:0]  r_tmo;
    logic [LEN_W-1:0]   w_cnt_inc;

    assign w_cnt_inc = r_cnt + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_tmo   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_len   <= cmd_len;
                        r_acc   <= cmd_init;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= (cmd_len == '0) ? S_RESULT : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (elem_valid) begin
                        r_a     <= elem_a;
                        r_b     <= elem_b;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_tmo <= r_tmo + c_TO_W'(1);
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (pe_out_valid) begin
                        r_acc   <= pe_psum_out;
                        r_cnt   <= w_cnt_inc;
                        r_state <= (w_cnt_inc == r_len) ? S_RESULT : S_FETCH;
                    end else if (r_tmo == c_TO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign elem_ready  = (r_state == S_FETCH);
    assign pe_in_valid = (r_state == S_ISSUE);
    assign res_valid   = (r_state == S_RESULT);
    assign busy        = (r_state != S_IDLE);

    assign pe_a_bits   = r_a;
    assign pe_b_bits   = r_b;
    assign pe_psum_in  = r_acc;
    assign res_data    = r_acc;
    assign res_count   = r_cnt;
    assign res_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pe_dot_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_dot_seq
// Description : Bench for pe_dot_seq with a behavioural FP32 pe and dot-product
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_dot_seq;

    localparam int c_LEN_W   = 8;
    localparam int c_TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [c_LEN_W-1:0] cmd_len = '0;
    logic [31:0]        cmd_init = 32'd0;
    logic               elem_valid = 1'b0;
    logic               elem_ready;
    logic [31:0]        elem_a = 32'd0;
    logic [31:0]        elem_b = 32'd0;
    logic               pe_in_valid;
    logic [31:0]        pe_a_bits;
    logic [31:0]        pe_b_bits;
    logic [31:0]        pe_psum_in;
    logic               pe_out_valid;
    logic [31:0]        pe_psum_out;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [31:0]        res_data;
    logic [c_LEN_W-1:0] res_count;
    logic               res_err;
    logic               busy;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pe_dot_seq #(.LEN_W(c_LEN_W), .TIMEOUT(c_TIMEOUT)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_init(cmd_init),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_a(elem_a), .elem_b(elem_b),
        .pe_in_valid(pe_in_valid), .pe_a_bits(pe_a_bits), .pe_b_bits(pe_b_bits),
        .pe_psum_in(pe_psum_in), .pe_out_valid(pe_out_valid), .pe_psum_out(pe_psum_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_count(res_count), .res_err(res_err), .busy(busy)
    );

    // FP32 <-> double for zeros and normals; enough for the exact values used here.
    function automatic real f32_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_fma(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] p);
        return real_to_f32(f32_to_real(a) * f32_to_real(b) + f32_to_real(p));
    endfunction

    function automatic logic [31:0] rnd_small();
        int k;
        k = int'($urandom_range(0, 14)) - 7;
        return real_to_f32(real'(k));
    endfunction

    // Behavioural pe: result a*b+psum, out_valid pe_lat cycles after the pulse.
    int          pe_lat    = 1;
    logic        pe_mute   = 1'b0;
    logic        pe_spur   = 1'b0;
    logic        pe_fire   = 1'b0;
    logic [31:0] pe_res    = 32'd0;
    int          pe_cd     = 0;
    int          pe_pulses = 0;

    assign pe_out_valid = pe_fire | pe_spur;
    assign pe_psum_out  = pe_spur ? 32'hDEADBEEF : pe_res;

    always @(posedge clk) begin
        pe_fire <= 1'b0;
        if (rst) begin
            pe_cd <= 0;
        end else if (pe_in_valid) begin
            pe_res    <= fp_fma(pe_a_bits, pe_b_bits, pe_psum_in);
            pe_pulses <= pe_pulses + 1;
            if (pe_lat == 1) pe_fire <= !pe_mute;
            else pe_cd <= pe_lat - 1;
        end else if (pe_cd != 0) begin
            pe_cd <= pe_cd - 1;
            if (pe_cd == 1) pe_fire <= !pe_mute;
        end
    end

    logic [31:0] pa [0:299];
    logic [31:0] pb [0:299];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_dot(input logic [31:0] init, input int n);
        logic [31:0] acc;
        acc = init;
        for (int i = 0; i < n; i++) acc = fp_fma(pa[i], pb[i], acc);
        return acc;
    endfunction

    // One complete job: command, operand stream, result with rdy cycles of back-pressure.
    task automatic run_job(input string tag, input logic [31:0] init, input int n,
                           input int gap, input int rdy, input logic spur,
                           input logic [31:0] exp_d, input int exp_c, input logic exp_e,
                           input int exp_lat);
        int t, idx, lat, p0;
        p0 = pe_pulses;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = c_LEN_W'(n);
        cmd_init  = init;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_init  = 32'd0;
        idx = 0;
        lat = 1;
        while (!res_valid && lat < 5000) begin
            pe_spur = spur && (lat == 1);
            if (idx < n && !pe_spur && (gap == 0 || $urandom_range(0, gap) == 0)) begin
                elem_valid = 1'b1;
                elem_a     = pa[idx];
                elem_b     = pb[idx];
                if (elem_ready) idx++;
            end else begin
                elem_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        pe_spur    = 1'b0;
        elem_valid = 1'b0;
        check({tag, " res_valid"}, 32'(res_valid), 32'd1);
        check({tag, " res_data"},  res_data, exp_d);
        check({tag, " res_count"}, 32'(res_count), 32'(exp_c));
        check({tag, " res_err"},   32'(res_err), 32'(exp_e));
        check({tag, " pulses"},    32'(pe_pulses - p0), 32'(exp_e ? exp_c + 1 : exp_c));
        if (exp_lat >= 0) check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        for (int i = 0; i < rdy; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 32'(res_valid), 32'd1);
            check({tag, " hold data"},  res_data, exp_d);
            check({tag, " hold count"}, 32'(res_count), 32'(exp_c));
            check({tag, " hold cmd_ready"}, 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, " idle valid"}, 32'(res_valid), 32'd0);
        check({tag, " idle cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] init;
        int n, gap, rdy;
        int t;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst cmd_ready",  32'(cmd_ready), 32'd1);
        check("rst elem_ready", 32'(elem_ready), 32'd0);
        check("rst pe_in_valid", 32'(pe_in_valid), 32'd0);
        check("rst res_valid",  32'(res_valid), 32'd0);
        check("rst res_data",   res_data, 32'd0);
        check("rst res_count",  32'(res_count), 32'd0);
        check("rst res_err",    32'(res_err), 32'd0);
        check("rst busy",       32'(busy), 32'd0);
        check("rst pe_a_bits",  pe_a_bits, 32'd0);

        // Directed dot products with known FP32 answers.
        pa[0] = 32'h3F800000; pb[0] = 32'h40400000;
        pa[1] = 32'h40000000; pb[1] = 32'h40800000;
        pe_lat = 3;
        run_job("t1", 32'h00000000, 2, 0, 0, 1'b0, 32'h41300000, 2, 1'b0, 1 + 2 * (2 + 3));
        run_job("t2", 32'h3F000000, 2, 0, 0, 1'b0, 32'h41380000, 2, 1'b0, 1 + 2 * (2 + 3));
        run_job("t3", 32'h40400000, 0, 0, 0, 1'b0, 32'h40400000, 0, 1'b0, 1);

        // Timeout: silent pe, then the boundary where the answer lands on the last cycle.
        pe_lat = 1; pe_mute = 1'b1;
        run_job("t4", 32'h40A00000, 3, 0, 0, 1'b0, 32'h40A00000, 0, 1'b1, 3 + c_TIMEOUT);
        pe_mute = 1'b0;
        pe_lat = c_TIMEOUT;
        run_job("tmo edge", 32'h00000000, 1, 0, 0, 1'b0, 32'h40400000, 1, 1'b0, 1 + 2 + c_TIMEOUT);
        pe_lat = c_TIMEOUT + 1;
        run_job("tmo late", 32'h3F800000, 1, 0, 2, 1'b0, 32'h3F800000, 0, 1'b1, 3 + c_TIMEOUT);
        repeat (4) @(negedge clk);

        // Back-pressure on the result, and a stray pe pulse while fetching.
        pe_lat = 2;
        run_job("t5", 32'h00000000, 2, 0, 5, 1'b0, 32'h41300000, 2, 1'b0, 1 + 2 * (2 + 2));
        run_job("spur", 32'h00000000, 2, 0, 0, 1'b1, 32'h41300000, 2, 1'b0, 2 + 2 * (2 + 2));

        // Reset while waiting on the pe in a 4-term job.
        pe_lat = 6;
        for (int i = 0; i < 4; i++) begin pa[i] = 32'h3F800000; pb[i] = 32'h3F800000; end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = c_LEN_W'(4); cmd_init = 32'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        elem_valid = 1'b1; elem_a = pa[0]; elem_b = pb[0];
        t = 0;
        while (pe_pulses == 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        elem_valid = 1'b0;
        @(negedge clk);
        check("mid busy before rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6 cmd_ready", 32'(cmd_ready), 32'd1);
        check("t6 busy",      32'(busy), 32'd0);
        check("t6 res_valid", 32'(res_valid), 32'd0);
        repeat (10) @(negedge clk);
        check("t6 still idle", 32'(cmd_ready), 32'd1);
        pa[0] = 32'h40000000; pb[0] = 32'h40000000;
        run_job("t6 new", 32'h00000000, 1, 0, 0, 1'b0, 32'h40800000, 1, 1'b0, 1 + (2 + 6));

        // Randomised jobs against the reference dot product.
        for (int j = 0; j < 20; j++) begin
            n      = int'($urandom_range(1, 6));
            gap    = int'($urandom_range(0, 2));
            rdy    = int'($urandom_range(0, 3));
            pe_lat = int'($urandom_range(1, 6));
            init   = rnd_small();
            for (int i = 0; i < n; i++) begin pa[i] = rnd_small(); pb[i] = rnd_small(); end
            run_job("rand", init, n, gap, rdy, 1'b0, ref_dot(init, n), n, 1'b0,
                    (gap == 0) ? 1 + n * (2 + pe_lat) : -1);
        end

        // Longest job the length field allows.
        pe_lat = 1;
        init = rnd_small();
        for (int i = 0; i < 255; i++) begin pa[i] = rnd_small(); pb[i] = rnd_small(); end
        run_job("max len", init, 255, 0, 1, 1'b0, ref_dot(init, 255), 255, 1'b0, 1 + 255 * 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
